// File: rtl/band_energy_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// band_energy_accumulator: sums contiguous FFT bin magnitudes into per-band
// energies and drains them downstream over valid/ready.  Rev 1.0
// ---------------------------------------------------------------------------
module band_energy_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int FFT_BINS   = 256,
  parameter int NUM_BANDS  = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        mag_in,
  input  logic                         mag_valid,
  input  logic                         frame_start,
  output logic                         mag_ready,
  output logic [ACC_WIDTH-1:0]         band_energy,
  output logic [$clog2(NUM_BANDS)-1:0] band_idx,
  output logic                         band_valid,
  output logic                         band_last,
  input  logic                         band_ready,
  output logic                         sat_flag,
  output logic                         sync_err
);

  localparam int BINS_PER_BAND = FFT_BINS / NUM_BANDS;
  localparam int BIN_W         = $clog2(FFT_BINS);
  localparam int BAND_W        = $clog2(NUM_BANDS);
  localparam int SUM_W         = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q [NUM_BANDS];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_BANDS];
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BAND_W-1:0]      band_idx_q, band_idx_d;
  logic [ACC_WIDTH-1:0]   band_energy_q, band_energy_d;
  logic                   band_valid_q, band_valid_d;
  logic                   sat_q, sat_d;
  logic                   sync_err_q, sync_err_d;

  logic                   w_accept;
  logic [BAND_W-1:0]      w_band;
  logic [BAND_W-1:0]      w_next_idx;
  logic [SUM_W-1:0]       w_sum;

  assign mag_ready  = (state_q != ST_DRAIN);
  assign w_accept   = mag_valid & mag_ready;
  assign w_band     = BAND_W'(bin_q / BIN_W'(BINS_PER_BAND));
  assign w_next_idx = band_idx_q + BAND_W'(1);
  // One extra bit catches the carry out; a set MSB means the band overflowed.
  assign w_sum      = {1'b0, acc_q[w_band]} + SUM_W'(mag_in);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    bin_d         = bin_q;
    band_idx_d    = band_idx_q;
    band_energy_d = band_energy_q;
    band_valid_d  = band_valid_q;
    sat_d         = sat_q;
    sync_err_d    = sync_err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept && frame_start) begin
          acc_d[0] = ACC_WIDTH'(mag_in);
          bin_d    = BIN_W'(1);
          sat_d    = 1'b0;
          state_d  = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (w_accept) begin
          if (frame_start) begin
            for (int i = 0; i < NUM_BANDS; i++) acc_d[i] = '0;
            acc_d[0]   = ACC_WIDTH'(mag_in);
            bin_d      = BIN_W'(1);
            sat_d      = 1'b0;
            sync_err_d = 1'b1;
          end else begin
            if (w_sum[ACC_WIDTH]) begin
              acc_d[w_band] = '1;
              sat_d         = 1'b1;
            end else begin
              acc_d[w_band] = w_sum[ACC_WIDTH-1:0];
            end
            bin_d = bin_q + BIN_W'(1);
            if (bin_q == BIN_W'(FFT_BINS - 1)) state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!band_valid_q) begin
          band_valid_d  = 1'b1;
          band_idx_d    = '0;
          band_energy_d = acc_q[0];
        end else if (band_ready) begin
          if (band_idx_q == BAND_W'(NUM_BANDS - 1)) begin
            for (int i = 0; i < NUM_BANDS; i++) acc_d[i] = '0;
            band_valid_d = 1'b0;
            band_idx_d   = '0;
            state_d      = ST_IDLE;
          end else begin
            band_idx_d    = w_next_idx;
            band_energy_d = acc_q[w_next_idx];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < NUM_BANDS; i++) acc_q[i] <= '0;
      bin_q         <= '0;
      band_idx_q    <= '0;
      band_energy_q <= '0;
      band_valid_q  <= 1'b0;
      sat_q         <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < NUM_BANDS; i++) acc_q[i] <= acc_d[i];
      bin_q         <= bin_d;
      band_idx_q    <= band_idx_d;
      band_energy_q <= band_energy_d;
      band_valid_q  <= band_valid_d;
      sat_q         <= sat_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign band_energy = band_energy_q;
  assign band_idx    = band_idx_q;
  assign band_valid  = band_valid_q;
  assign band_last   = band_valid_q & (band_idx_q == BAND_W'(NUM_BANDS - 1));
  assign sat_flag    = sat_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_band_energy_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_band_energy_accumulator: directed + random frames against a band-sum
// model; a 40-bit and a 32-bit accumulator instance share the stimulus. Rev 1.0
// ---------------------------------------------------------------------------
module tb_band_energy_accumulator;

  localparam int BINS  = 16;
  localparam int BANDS = 4;
  localparam int BPB   = BINS / BANDS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mag_in;
  logic        mag_valid;
  logic        frame_start;
  logic        band_ready;

  logic        mag_ready,   mag_ready_s;
  logic [39:0] band_energy;
  logic [31:0] band_energy_s;
  logic [1:0]  band_idx,    band_idx_s;
  logic        band_valid,  band_valid_s;
  logic        band_last,   band_last_s;
  logic        sat_flag,    sat_flag_s;
  logic        sync_err,    sync_err_s;

  int total = 0;
  int bad   = 0;

  logic [31:0]     frame_q[$];
  bit              in_frame = 0;
  bit              m_sync   = 0;
  bit              m_sat40  = 0;
  bit              m_sat32  = 0;
  longint unsigned exp40[BANDS];
  longint unsigned exp32[BANDS];

  always #5 clk = ~clk;

  band_energy_accumulator #(
    .DATA_WIDTH(32), .FFT_BINS(BINS), .NUM_BANDS(BANDS), .ACC_WIDTH(40)
  ) dut (
    .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid),
    .frame_start(frame_start), .mag_ready(mag_ready),
    .band_energy(band_energy), .band_idx(band_idx), .band_valid(band_valid),
    .band_last(band_last), .band_ready(band_ready), .sat_flag(sat_flag),
    .sync_err(sync_err)
  );

  band_energy_accumulator #(
    .DATA_WIDTH(32), .FFT_BINS(BINS), .NUM_BANDS(BANDS), .ACC_WIDTH(32)
  ) dut_s (
    .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid),
    .frame_start(frame_start), .mag_ready(mag_ready_s),
    .band_energy(band_energy_s), .band_idx(band_idx_s), .band_valid(band_valid_s),
    .band_last(band_last_s), .band_ready(band_ready), .sat_flag(sat_flag_s),
    .sync_err(sync_err_s)
  );

  initial begin
    #400000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Band b is the saturating running sum of its bins, clamped at 2^w-1.
  task automatic compute();
    for (int w = 0; w < 2; w++) begin
      longint unsigned mx;
      bit st;
      mx = (w == 0) ? 64'h00FF_FFFF_FFFF : 64'h0000_FFFF_FFFF;
      st = 0;
      for (int b = 0; b < BANDS; b++) begin
        longint unsigned s;
        s = 0;
        for (int k = 0; k < BPB; k++) begin
          s = s + 64'(frame_q[b*BPB + k]);
          if (s > mx) begin
            s  = mx;
            st = 1;
          end
        end
        if (w == 0) exp40[b] = s; else exp32[b] = s;
      end
      if (w == 0) m_sat40 = st; else m_sat32 = st;
    end
  endtask

  task automatic send(input logic [31:0] v, input bit fs);
    @(negedge clk);
    chk("mag_ready_idle", 64'(mag_ready), 64'd1);
    chk("mag_ready_idle_s", 64'(mag_ready_s), 64'd1);
    mag_valid   = 1'b1;
    mag_in      = v;
    frame_start = fs;
    if (fs) begin
      if (in_frame) m_sync = 1;
      frame_q.delete();
      in_frame = 1;
      frame_q.push_back(v);
    end else if (in_frame) begin
      frame_q.push_back(v);
    end
    if (in_frame && frame_q.size() == BINS) begin
      in_frame = 0;
      compute();
    end
  endtask

  task automatic gap();
    @(negedge clk);
    mag_valid   = 1'b0;
    mag_in      = $urandom;
    frame_start = 1'($urandom);
  endtask

  task automatic check_band(input int b);
    chk("band_valid", 64'(band_valid), 64'd1);
    chk("band_idx", 64'(band_idx), 64'(b));
    chk("band_energy", 64'(band_energy), exp40[b]);
    chk("band_last", 64'(band_last), 64'(b == BANDS - 1));
    chk("sat_flag", 64'(sat_flag), 64'(m_sat40));
    chk("sync_err", 64'(sync_err), 64'(m_sync));
    chk("mag_ready_drain", 64'(mag_ready), 64'd0);
    chk("band_valid_s", 64'(band_valid_s), 64'd1);
    chk("band_idx_s", 64'(band_idx_s), 64'(b));
    chk("band_energy_s", 64'(band_energy_s), exp32[b]);
    chk("band_last_s", 64'(band_last_s), 64'(b == BANDS - 1));
    chk("sat_flag_s", 64'(sat_flag_s), 64'(m_sat32));
    chk("sync_err_s", 64'(sync_err_s), 64'(m_sync));
  endtask

  // abort_at >= 0 pulses reset while that band is first presented.
  task automatic drain(input int stall, input int abort_at);
    @(negedge clk);
    mag_valid   = 1'b0;
    frame_start = 1'b0;
    chk("band_valid_latency", 64'(band_valid), 64'd0);
    chk("mag_ready_after_last", 64'(mag_ready), 64'd0);
    band_ready = (stall == 0);
    for (int b = 0; b < BANDS; b++) begin
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        check_band(b);
        if (b == abort_at && s == 0) begin
          rst        = 1'b0;
          band_ready = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          chk("abort_band_valid", 64'(band_valid), 64'd0);
          chk("abort_band_idx", 64'(band_idx), 64'd0);
          chk("abort_band_energy", 64'(band_energy), 64'd0);
          chk("abort_sync_err", 64'(sync_err), 64'd0);
          chk("abort_mag_ready", 64'(mag_ready), 64'd1);
          chk("abort_band_valid_s", 64'(band_valid_s), 64'd0);
          in_frame = 0;
          m_sync   = 0;
          frame_q.delete();
          band_ready = 1'b1;
          return;
        end
        band_ready = (s == stall) ? 1'b1 : 1'b0;
      end
      if (b < BANDS - 1 && stall > 0) begin
        // ready drops again right after the handshake edge
        @(negedge clk);
        check_band(b + 1);
        band_ready = 1'b0;
        if (stall > 1) begin
          for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            check_band(b + 1);
          end
        end
        @(negedge clk);
        check_band(b + 1);
        band_ready = 1'b1;
        b++;
        if (b == BANDS - 1) break;
      end
    end
    @(negedge clk);
    chk("end_band_valid", 64'(band_valid), 64'd0);
    chk("end_band_last", 64'(band_last), 64'd0);
    chk("end_mag_ready", 64'(mag_ready), 64'd1);
    chk("end_band_valid_s", 64'(band_valid_s), 64'd0);
    band_ready = 1'b1;
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < BINS; i++) send(32'(i + 1), i == 0);
  endtask

  initial begin
    rst         = 1'b0;
    mag_in      = '0;
    mag_valid   = 1'b0;
    frame_start = 1'b0;
    band_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_band_valid", 64'(band_valid), 64'd0);
    chk("rst_band_idx", 64'(band_idx), 64'd0);
    chk("rst_band_energy", 64'(band_energy), 64'd0);
    chk("rst_band_last", 64'(band_last), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    chk("rst_mag_ready", 64'(mag_ready), 64'd1);
    rst = 1'b1;

    // Nominal ramp, then the same frame under backpressure.
    ramp_frame();
    drain(0, -1);
    ramp_frame();
    drain(3, -1);

    // Saturating frame, then a clean frame of ones.
    for (int i = 0; i < BINS; i++) send(32'hFFFF_FFFF, i == 0);
    drain(0, -1);
    for (int i = 0; i < BINS; i++) send(32'd1, i == 0);
    drain(1, -1);

    // Resync at bin 6.
    for (int i = 0; i < 6; i++) send(32'd1, i == 0);
    for (int i = 0; i < BINS; i++) send(32'd2, i == 0);
    drain(0, -1);

    // IDLE junk plus gapped input.
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    for (int i = 0; i < BINS; i++) begin
      send(32'(i + 1), i == 0);
      if (i < BINS - 1) gap();
    end
    drain(0, -1);

    // Reset during drain, then a fresh frame.
    ramp_frame();
    drain(0, 2);
    for (int i = 0; i < BINS; i++) send(32'(3 * i + 5), i == 0);
    drain(0, -1);

    // Random frames, some biased high to provoke 32-bit saturation.
    for (int f = 0; f < 6; f++) begin
      bit hi;
      int st;
      hi = 1'($urandom);
      st = $urandom_range(0, 2);
      for (int i = 0; i < BINS; i++) begin
        send(hi ? ($urandom | 32'hC000_0000) : ($urandom >> 4), i == 0);
        if ($urandom_range(0, 3) == 0 && i < BINS - 1) gap();
      end
      drain(st, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
